// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: per-burst two-port Avalon-MM arbiter onto one SDRAM port with in-order read return routing.
// DDR_ARB_FIXED_PRIO_EN selects strict port-0 priority instead of round-robin.
module ddr_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int BURST_WIDTH = 7,
  parameter int RD_TAGS     = 8
) (
  input  logic                    sys_clk_clk,
  input  logic                    sys_rstn_reset_n,
  input  logic [ADDR_WIDTH-1:0]   s0_address,
  input  logic [BURST_WIDTH-1:0]  s0_burstcount,
  input  logic                    s0_read,
  input  logic                    s0_write,
  input  logic [DATA_WIDTH-1:0]   s0_writedata,
  input  logic [DATA_WIDTH/8-1:0] s0_byteenable,
  output logic                    s0_waitrequest,
  output logic [DATA_WIDTH-1:0]   s0_readdata,
  output logic                    s0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [BURST_WIDTH-1:0]  s1_burstcount,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [BURST_WIDTH-1:0]  m_burstcount,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  input  logic                    m_waitrequest,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  input  logic                    m_readdatavalid
);
  localparam int TW = $clog2(RD_TAGS);
  localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_t;
  state_t state;
  logic gnt;
  logic [BURST_WIDTH-1:0] wr_cnt, rd_cnt, bc_g, bc_eff, rd_rem;
  logic [TW:0] wr_ptr, rd_ptr;
  logic tag_port [RD_TAGS];
  logic [BURST_WIDTH-1:0] tag_len [RD_TAGS];
  logic full, empty, el0, el1, win, win_wr, rd_g, wr_g, wr_acc, push, pop, head, beat;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[TW] != rd_ptr[TW]) && (wr_ptr[TW-1:0] == rd_ptr[TW-1:0]);
  assign el0 = s0_write | (s0_read & ~full);
  assign el1 = s1_write | (s1_read & ~full);
`ifdef DDR_ARB_FIXED_PRIO_EN
  assign win = ~el0;
`else
  logic rr_ptr;
  assign win = (el0 & el1) ? ~rr_ptr : el1;
`endif
  assign win_wr = win ? s1_write : s0_write;
  assign rd_g = gnt ? s1_read : s0_read;
  assign wr_g = gnt ? s1_write : s0_write;
  assign bc_g = gnt ? s1_burstcount : s0_burstcount;
  assign bc_eff = (bc_g == '0) ? ONE : bc_g;
  assign m_address = gnt ? s1_address : s0_address;
  assign m_burstcount = bc_eff;
  assign m_writedata = gnt ? s1_writedata : s0_writedata;
  assign m_byteenable = gnt ? s1_byteenable : s0_byteenable;
  assign m_write = (state == WR_BURST) & wr_g;
  assign m_read = (state == RD_CMD) & rd_g;
  assign s0_waitrequest = (state == IDLE) | gnt | m_waitrequest;
  assign s1_waitrequest = (state == IDLE) | ~gnt | m_waitrequest;
  assign wr_acc = m_write & ~m_waitrequest;
  assign push = m_read & ~m_waitrequest;
  assign head = tag_port[rd_ptr[TW-1:0]];
  assign rd_rem = (rd_cnt == '0) ? tag_len[rd_ptr[TW-1:0]] : rd_cnt;
  assign beat = m_readdatavalid & ~empty;
  assign pop = beat & (rd_rem <= ONE);
  assign s0_readdatavalid = beat & ~head;
  assign s1_readdatavalid = beat & head;
  assign s0_readdata = m_readdata;
  assign s1_readdata = m_readdata;
  // Grant FSM: pick a winner in IDLE, hold it for a whole write burst or one read command.
  always_ff @(posedge sys_clk_clk) begin
    if (!sys_rstn_reset_n) begin
      state <= IDLE;
      gnt <= 1'b0;
      wr_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (el0 | el1) begin
          gnt <= win;
          state <= win_wr ? WR_BURST : RD_CMD;
        end
        WR_BURST: if (wr_acc) begin
          if ((wr_cnt == '0) ? (bc_eff == ONE) : (wr_cnt == ONE)) begin
            state <= IDLE;
            wr_cnt <= '0;
          end else wr_cnt <= ((wr_cnt == '0) ? bc_eff : wr_cnt) - ONE;
        end
        RD_CMD: if (push || !rd_g) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifndef DDR_ARB_FIXED_PRIO_EN
  // Round-robin pointer remembers the last granted port; starts at 1 so port 0 wins the first tie.
  always_ff @(posedge sys_clk_clk) begin
    if (!sys_rstn_reset_n) rr_ptr <= 1'b1;
    else if (state == IDLE && (el0 | el1)) rr_ptr <= win;
  end
`endif
  // Tag FIFO pointers and head beat counter; returning beats with no outstanding tag are dropped.
  always_ff @(posedge sys_clk_clk) begin
    if (!sys_rstn_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (beat) rd_cnt <= pop ? '0 : rd_rem - ONE;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // Tag storage: issuing port and effective burst length of each accepted read.
  always_ff @(posedge sys_clk_clk) begin
    if (push) begin
      tag_port[wr_ptr[TW-1:0]] <= gnt;
      tag_len[wr_ptr[TW-1:0]] <= bc_eff;
    end
  end
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: scoreboard bench for ddr_port_arbiter with directed bursts and hand-computed expectations.
module tb_ddr_port_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [31:0] s0_address = '0, s1_address = '0, m_address;
  logic [6:0] s0_burstcount = '0, s1_burstcount = '0, m_burstcount;
  logic s0_read = 0, s0_write = 0, s1_read = 0, s1_write = 0;
  logic [127:0] s0_writedata = '0, s1_writedata = '0, m_writedata, s0_readdata, s1_readdata;
  logic [15:0] s0_byteenable = '0, s1_byteenable = '0, m_byteenable;
  logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic m_read, m_write;
  logic m_waitrequest = 1'b0;
  logic [127:0] m_readdata = '0;
  logic m_readdatavalid = 1'b0;
  typedef struct {logic wr; logic [31:0] addr; logic [6:0] bc; logic [127:0] data; logic [15:0] be;} cmd_t;
  typedef struct {logic port; logic [127:0] data;} rd_t;
  cmd_t exp_cmd[$];
  rd_t exp_rd[$];
  cmd_t ce;
  rd_t re;
  int total = 0, fails = 0;
  int f, t, f1, t1, t9, bad, g1;
  ddr_port_arbiter dut (
    .sys_clk_clk(clk), .sys_rstn_reset_n(rstn),
    .s0_address(s0_address), .s0_burstcount(s0_burstcount), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_burstcount(s1_burstcount), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drv(input int p, input logic rd, input logic wr, input logic [31:0] a, input logic [6:0] bc, input logic [127:0] d);
    if (p == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_burstcount = bc; s0_writedata = d; s0_byteenable = 16'hFFFF;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_burstcount = bc; s1_writedata = d; s1_byteenable = 16'h0F0F;
    end
  endtask
  task automatic ecmd(input int p, input logic wr, input logic [31:0] a, input logic [6:0] bc, input logic [127:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.bc = bc; c.data = d; c.be = (p == 0) ? 16'hFFFF : 16'h0F0F;
    exp_cmd.push_back(c);
  endtask
  task automatic erd(input logic p, input logic [127:0] d);
    rd_t r;
    r.port = p; r.data = d;
    exp_rd.push_back(r);
  endtask
  task automatic wr_burst(input int p, input logic [31:0] a, input logic [6:0] bc, input logic [127:0] d0, output int first, output int tot);
    int n, k;
    logic w;
    n = (bc == 0) ? 1 : int'(bc);
    first = -1; tot = 0;
    for (int i = 0; i < n; i++) begin
      drv(p, 1'b0, 1'b1, a, bc, d0 + 128'(i));
      k = 0;
      do begin
        @(negedge clk); tot++; k++;
        w = (p == 0) ? s0_waitrequest : s1_waitrequest;
      end while (w && k < 64);
      chk("wr_beat_accept", w, 1'b0);
      if (i == 0) first = tot;
      @(posedge clk); #1;
      if (w) break;
    end
    drv(p, 1'b0, 1'b0, 32'h0, 7'h0, 128'h0);
  endtask
  task automatic rd_cmd(input int p, input logic [31:0] a, input logic [6:0] bc, output int tot);
    int k;
    logic w;
    drv(p, 1'b1, 1'b0, a, bc, 128'h0);
    tot = 0; k = 0;
    do begin
      @(negedge clk); tot++; k++;
      w = (p == 0) ? s0_waitrequest : s1_waitrequest;
    end while (w && k < 64);
    chk("rd_cmd_accept", w, 1'b0);
    @(posedge clk); #1;
    drv(p, 1'b0, 1'b0, 32'h0, 7'h0, 128'h0);
  endtask
  task automatic ret_beats(input int n, input logic [127:0] d0);
    for (int i = 0; i < n; i++) begin
      m_readdata = d0 + 128'(i); m_readdatavalid = 1'b1;
      @(posedge clk); #1;
    end
    m_readdatavalid = 1'b0;
  endtask
  task automatic do_reset;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask
  // Command monitor: every beat/command accepted by the memory side must match the head expectation.
  always @(negedge clk) begin
    if ((m_write || m_read) && !m_waitrequest) begin
      if (exp_cmd.size() == 0) begin
        total++; fails++;
        $display("FAIL cmd_unexpected: got wr=%0b addr=%0h data=%0h expected no command", m_write, m_address, m_writedata);
      end else begin
        ce = exp_cmd.pop_front();
        chk("cmd_kind", m_write, ce.wr);
        chk("cmd_addr", m_address, ce.addr);
        chk("cmd_bc", m_burstcount, ce.bc);
        if (ce.wr) begin
          chk("cmd_wdata", m_writedata, ce.data);
          chk("cmd_be", m_byteenable, ce.be);
        end
      end
    end
  end
  // Read-return monitor: each valid beat goes to exactly one port, in tag order.
  always @(negedge clk) begin
    if (s0_readdatavalid || s1_readdatavalid) begin
      chk("rd_one_port", s0_readdatavalid & s1_readdatavalid, 1'b0);
      if (exp_rd.size() == 0) begin
        total++; fails++;
        $display("FAIL rd_unexpected: got v0=%0b v1=%0b data=%0h expected no beat", s0_readdatavalid, s1_readdatavalid, m_readdata);
      end else begin
        re = exp_rd.pop_front();
        chk("rd_port", s1_readdatavalid, re.port);
        chk("rd_data", re.port ? s1_readdata : s0_readdata, re.data);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s0_wait", s0_waitrequest, 1'b1);
    chk("rst_s1_wait", s1_waitrequest, 1'b1);
    chk("rst_m_read", m_read, 1'b0);
    chk("rst_m_write", m_write, 1'b0);
    chk("rst_rdv", s0_readdatavalid | s1_readdatavalid, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) ecmd(0, 1'b1, 32'h1000, 7'd4, 128'hA0 + 128'(i));
    bad = 0;
    fork
      wr_burst(0, 32'h1000, 7'd4, 128'hA0, f, t);
      repeat (6) begin @(negedge clk); if (s1_waitrequest !== 1'b1) bad++; end
    join
    chk("t1_latency", f, 2);
    chk("t1_length", t, 5);
    chk("t1_s1_wait_held", bad, 0);
    @(negedge clk);
    chk("t1_idle_after", s0_waitrequest, 1'b1);
    @(posedge clk); #1;
    do_reset;
    ecmd(0, 1'b1, 32'h2000, 7'd2, 128'hB0);
    ecmd(0, 1'b1, 32'h2000, 7'd2, 128'hB1);
    ecmd(1, 1'b1, 32'h3000, 7'd2, 128'hC0);
    ecmd(1, 1'b1, 32'h3000, 7'd2, 128'hC1);
    fork
      wr_burst(0, 32'h2000, 7'd2, 128'hB0, f, t);
      wr_burst(1, 32'h3000, 7'd2, 128'hC0, f1, t1);
    join
    chk("t2_p0_first", f, 2);
    chk("t2_p0_end", t, 3);
    chk("t2_p1_first", f1, 5);
    chk("t2_total_cycles", t1, 6);
    do_reset;
    ecmd(0, 1'b0, 32'h4000, 7'd8, 128'h0);
    ecmd(1, 1'b0, 32'h5000, 7'd4, 128'h0);
    rd_cmd(0, 32'h4000, 7'd8, t);
    chk("t3_rd0_latency", t, 2);
    rd_cmd(1, 32'h5000, 7'd4, t);
    chk("t3_rd1_latency", t, 2);
    for (int i = 0; i < 12; i++) erd(i >= 8, 128'hD0 + 128'(i));
    ret_beats(12, 128'hD0);
    do_reset;
    for (int i = 0; i < 8; i++) begin
      ecmd(1, 1'b0, 32'h5100 + 32'(16 * i), 7'd1, 128'h0);
      rd_cmd(1, 32'h5100 + 32'(16 * i), (i < 2) ? 7'd0 : 7'd1, t);
    end
    ecmd(0, 1'b1, 32'h6000, 7'd1, 128'hE0);
    ecmd(1, 1'b0, 32'h5200, 7'd1, 128'h0);
    fork
      rd_cmd(1, 32'h5200, 7'd1, t9);
      begin
        bad = 0;
        repeat (3) begin @(negedge clk); if (!s1_waitrequest) bad++; end
        @(posedge clk); #1;
        wr_burst(0, 32'h6000, 7'd1, 128'hE0, f, t);
        chk("t4_wr_while_full", f, 2);
        repeat (2) begin @(negedge clk); if (!s1_waitrequest) bad++; end
        chk("t4_full_stall", bad, 0);
        @(posedge clk); #1;
        erd(1'b1, 128'hF0);
        ret_beats(1, 128'hF0);
      end
    join
    for (int i = 0; i < 8; i++) erd(1'b1, 128'hF1 + 128'(i));
    ret_beats(8, 128'hF1);
    do_reset;
    ecmd(1, 1'b0, 32'h8000, 7'd2, 128'h0);
    rd_cmd(1, 32'h8000, 7'd2, t);
    for (int i = 0; i < 3; i++) ecmd(0, 1'b1, 32'h7000, 7'd16, 128'h100 + 128'(i));
    drv(0, 1'b0, 1'b1, 32'h7000, 7'd16, 128'h100);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b1, 32'h7000, 7'd16, 128'h101);
    @(negedge clk);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b1, 32'h7000, 7'd16, 128'h102);
    rstn = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    drv(0, 1'b0, 1'b0, 32'h0, 7'h0, 128'h0);
    @(negedge clk);
    chk("t5_m_write_cleared", m_write, 1'b0);
    chk("t5_m_read_cleared", m_read, 1'b0);
    chk("t5_s0_wait", s0_waitrequest, 1'b1);
    chk("t5_s1_wait", s1_waitrequest, 1'b1);
    @(posedge clk); #1;
    bad = 0;
    fork
      ret_beats(2, 128'h900);
      repeat (2) begin @(negedge clk); if (s0_readdatavalid || s1_readdatavalid) bad++; end
    join
    chk("t5_stale_beats_dropped", bad, 0);
    @(posedge clk); #1;
    ecmd(1, 1'b1, 32'h7100, 7'd1, 128'h150);
    wr_burst(1, 32'h7100, 7'd1, 128'h150, f, t);
    chk("t5_idle_regrant", f, 2);
    do_reset;
`ifdef DDR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) ecmd(0, 1'b1, 32'hA000, 7'd1, 128'h200);
`else
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) ecmd(0, 1'b1, 32'hA000, 7'd1, 128'h200);
      else ecmd(1, 1'b1, 32'hB000, 7'd1, 128'h300);
    end
`endif
    drv(0, 1'b0, 1'b1, 32'hA000, 7'd1, 128'h200);
    drv(1, 1'b0, 1'b1, 32'hB000, 7'd1, 128'h300);
    g1 = 0;
    repeat (12) begin @(negedge clk); if (!s1_waitrequest) g1++; end
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 32'h0, 7'h0, 128'h0);
    drv(1, 1'b0, 1'b0, 32'h0, 7'h0, 128'h0);
`ifdef DDR_ARB_FIXED_PRIO_EN
    chk("t6_p1_grants", g1, 0);
`else
    chk("t6_p1_grants", g1, 3);
`endif
    repeat (4) @(negedge clk);
    chk("end_cmd_queue_drained", exp_cmd.size(), 0);
    chk("end_rd_queue_drained", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
